// File: rtl/i_mem_writer_if.sv
// Load-command and byte-write-port bundle between a program source and the instruction-memory loader.
interface i_mem_writer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] num_words;
  logic [31:0]       word_in;
  logic              word_valid;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] words_done;

  modport master (
    output start, start_addr, num_words, word_in, word_valid,
    input  word_ready, mem_we, mem_waddr, mem_wdata, busy, done, words_done
  );

  modport slave (
    input  start, start_addr, num_words, word_in, word_valid,
    output word_ready, mem_we, mem_waddr, mem_wdata, busy, done, words_done
  );
endinterface

// File: rtl/i_mem_writer.sv
// Program loader: splits 32-bit words into little-endian byte writes, 4 write cycles per word.
// Latency: accept at edge N -> bytes on cycles N+1..N+4, 5-cycle throughput; word_ready low while writing.
module i_mem_writer #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  i_mem_writer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = BYTE_MASK & ~ADDR_W'(3);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] left_q;
  logic [ADDR_W-1:0] words_done_q;
  logic [31:0]       word_q;
  logic [1:0]        b_q;
  logic [7:0]        wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.num_words == '0) ? DONE : ACCEPT;
      ACCEPT:  if (bus.word_valid) state_d = WRITE;
      // left_q still counts the word being written, so 1 means this is the last one
      WRITE:   if (b_q == 2'd3) state_d = (left_q == ADDR_W'(1)) ? DONE : ACCEPT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      left_q       <= '0;
      words_done_q <= '0;
      word_q       <= '0;
      b_q          <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q       <= bus.start_addr & WORD_MASK;
            left_q       <= bus.num_words;
            words_done_q <= '0;
          end
        end
        ACCEPT: begin
          if (bus.word_valid) begin
            word_q  <= bus.word_in;
            b_q     <= 2'd0;
            wdata_q <= bus.word_in[7:0];
          end
        end
        WRITE: begin
          addr_q <= (addr_q + ADDR_W'(1)) & BYTE_MASK;
          b_q    <= b_q + 2'd1;
          // wdata_q is staged one byte ahead and holds the top byte once the word is done
          case (b_q)
            2'd0:    wdata_q <= word_q[15:8];
            2'd1:    wdata_q <= word_q[23:16];
            2'd2:    wdata_q <= word_q[31:24];
            default: wdata_q <= wdata_q;
          endcase
          if (b_q == 2'd3) begin
            left_q <= left_q - ADDR_W'(1);
            if (words_done_q != '1) words_done_q <= words_done_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.word_ready = (state_q == ACCEPT);
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.mem_waddr  = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.words_done = words_done_q;

endmodule

// File: tb/tb_i_mem_writer.sv
// Bench for i_mem_writer: table of loads checked through a byte-write scoreboard and a fetch model.
module tb_i_mem_writer;

  logic clk;
  logic rst_n;

  i_mem_writer_if #(.ADDR_W(32)) bus ();

  i_mem_writer #(.MEM_BYTES(64), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_addr;
    logic [31:0] num_words;
    int          seed;
    int          stall;
    logic [31:0] exp_base;
    logic [31:0] exp_wd;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  dat;
  } wr_t;

  int          n_cmp;
  int          n_bad;
  wr_t         exp_q[$];
  logic [7:0]  tb_mem [64];
  logic [31:0] prog   [16];
  vec_t        vecs   [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fetch(input logic [31:0] a);
    logic [5:0] b;
    b = a[5:0];
    return {tb_mem[b + 6'd3], tb_mem[b + 6'd2], tb_mem[b + 6'd1], tb_mem[b]};
  endfunction

  // Scoreboard: every byte write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      tb_mem[bus.mem_waddr[5:0]] = bus.mem_wdata;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", bus.mem_waddr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_waddr, e.addr);
        check("wr_data", {24'd0, bus.mem_wdata}, {24'd0, e.dat});
      end
    end
  end

  task automatic run_load(input vec_t v);
    int          j, busy_cyc, dones, stall, guard;
    logic        fin;
    logic [31:0] w;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = v.start_addr;
    bus.num_words  = v.num_words;
    bus.word_valid = 1'b0;
    j = 0; busy_cyc = 0; dones = 0; stall = v.stall; fin = 1'b0; guard = 0;
    while (!fin && guard < 300) begin
      @(negedge clk);
      guard++;
      bus.start      = 1'b0;
      bus.word_valid = 1'b0;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        dones++;
        check("done_words", bus.words_done, v.exp_wd);
      end
      if (bus.word_ready) begin
        if (stall > 0) begin
          check("stall_no_we", {31'd0, bus.mem_we}, 32'd0);
          if (stall == 5) begin
            bus.start      = 1'b1;
            bus.start_addr = 32'd40;
            bus.num_words  = 32'd7;
          end
          stall--;
        end else if (j < int'(v.num_words)) begin
          w = prog[(v.seed + j) % 16];
          bus.word_in    = w;
          bus.word_valid = 1'b1;
          for (int b = 0; b < 4; b++)
            exp_q.push_back('{(v.exp_base + 32'(4 * j + b)) % 32'd64, w[8*b +: 8]});
          j++;
        end
      end
      if (!bus.busy && busy_cyc > 0) fin = 1'b1;
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_timeout: got busy after %0d cycles, expected idle", guard);
    end
    check("load_cycles", 32'(busy_cyc + 1), 32'(v.exp_cycles));
    check("done_pulses", 32'(dones), 32'd1);
    check("words_done_hold", bus.words_done, v.exp_wd);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < int'(v.num_words); k++)
      check("fetch", fetch(v.exp_base + 32'(4 * k)), prog[(v.seed + k) % 16]);
  endtask

  initial begin
    int   guard;
    logic found;
    vec_t rv;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) tb_mem[i] = 8'h00;
    prog = '{32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825,
             32'h0022182A, 32'h20430005, 32'h8C240004, 32'hAC240008,
             32'h3C010001, 32'h34210010, 32'h1022FFFE, 32'h1422FFFD,
             32'h08000000, 32'h00000000, 32'h0C000003, 32'h0441FFF0};
    // start_addr, num_words, seed, stall, exp_base, exp_words_done, exp_cycles
    vecs[0] = '{32'd0,  32'd1,  0, 0,  32'd0,  32'd1,  7};
    vecs[1] = '{32'd0,  32'd16, 0, 0,  32'd0,  32'd16, 82};
    vecs[2] = '{32'd62, 32'd2,  5, 0,  32'd60, 32'd2,  12};
    vecs[3] = '{32'd0,  32'd0,  0, 0,  32'd0,  32'd0,  2};
    vecs[4] = '{32'd8,  32'd2,  3, 10, 32'd8,  32'd2,  22};
    vecs[5] = '{32'd17, 32'd3,  9, 0,  32'd16, 32'd3,  17};

    bus.start = 1'b0; bus.start_addr = '0; bus.num_words = '0;
    bus.word_in = '0; bus.word_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {28'd0, bus.word_ready, bus.mem_we, bus.busy, bus.done}, 32'd0);
    check("reset_waddr", bus.mem_waddr, 32'd0);
    check("reset_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    check("reset_words_done", bus.words_done, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_load(vecs[i]);

    // Reset during the second byte of a word aborts it with no done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = 32'd20; bus.num_words = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_seq_ready", {31'd0, bus.word_ready}, 32'd1);
    bus.word_in = 32'hA1B2C3D4;
    bus.word_valid = 1'b1;
    exp_q.push_back('{32'd20, 8'hD4});
    exp_q.push_back('{32'd21, 8'hC3});
    @(negedge clk);
    bus.word_valid = 1'b0;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 10) begin
      if (bus.mem_we && bus.mem_waddr == 32'd21) found = 1'b1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    check("rst_seq_byte1_seen", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {28'd0, bus.word_ready, bus.mem_we, bus.busy, bus.done}, 32'd0);
    check("async_rst_waddr", bus.mem_waddr, 32'd0);
    check("async_rst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    check("async_rst_words_done", bus.words_done, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_idle", {30'd0, bus.busy, bus.done}, 32'd0);
    end
    check("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    rv = '{32'd36, 32'd2, 11, 0, 32'd36, 32'd2, 12};
    run_load(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
